// File: rtl/wb_stage_pkg.sv
// Shared codes, widths and payload type for the write-back stage.
// Load-type encodings match the MEM stage's ms_load_op field.
package wb_stage_pkg;

    localparam int GPR_W  = 5;
    localparam int DATA_W = 32;

    localparam logic [2:0] LOAD_LW  = 3'd0;
    localparam logic [2:0] LOAD_LB  = 3'd1;
    localparam logic [2:0] LOAD_LBU = 3'd2;
    localparam logic [2:0] LOAD_LH  = 3'd3;
    localparam logic [2:0] LOAD_LHU = 3'd4;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic              gr_we;
        logic [GPR_W-1:0]  dest;
        logic              res_from_mem;
        logic [2:0]        load_op;
        logic [1:0]        addr_low;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] mem_rdata;
    } ws_payload_t;

    function automatic logic [DATA_W-1:0] sext8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    function automatic logic [DATA_W-1:0] zext8(input logic [7:0] b);
        return {24'h00_0000, b};
    endfunction

    function automatic logic [DATA_W-1:0] sext16(input logic [15:0] h);
        return {{16{h[15]}}, h};
    endfunction

    function automatic logic [DATA_W-1:0] zext16(input logic [15:0] h);
        return {16'h0000, h};
    endfunction

    // Empty payload; the PC is parameterised by the stage instance.
    function automatic ws_payload_t payload_reset(input logic [DATA_W-1:0] pc);
        ws_payload_t p;
        p              = '0;
        p.pc           = pc;
        return p;
    endfunction

endpackage

// File: rtl/wb_stage_if.sv
// MEM -> WB pipeline bus: valid/allowin handshake plus instruction payload.
// master = MEM stage, slave = WB stage.
interface wb_stage_if;
    import wb_stage_pkg::*;

    logic              ms_to_ws_valid;
    logic [DATA_W-1:0] ms_pc;
    logic              ms_gr_we;
    logic [GPR_W-1:0]  ms_dest;
    logic              ms_res_from_mem;
    logic [2:0]        ms_load_op;
    logic [1:0]        ms_addr_low;
    logic [DATA_W-1:0] ms_alu_result;
    logic [DATA_W-1:0] ms_mem_rdata;
    logic              ws_allowin;

    modport master (
        output ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_res_from_mem,
               ms_load_op, ms_addr_low, ms_alu_result, ms_mem_rdata,
        input  ws_allowin
    );

    modport slave (
        input  ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_res_from_mem,
               ms_load_op, ms_addr_low, ms_alu_result, ms_mem_rdata,
        output ws_allowin
    );

endinterface

// File: rtl/wb_stage_load_ext.sv
// Load-data alignment: picks the addressed byte/halfword from the raw SRAM
// word and sign- or zero-extends it. Unknown load codes pass the word through.
module wb_stage_load_ext
    import wb_stage_pkg::*;
(
    input  logic [DATA_W-1:0] rdata,
    input  logic [2:0]        load_op,
    input  logic [1:0]        addr_low,
    output logic [DATA_W-1:0] ext
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select from the low address bits.
    always_comb begin
        byte_s = rdata[7:0];
        case (addr_low)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
        half_s = addr_low[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extension by load type.
    always_comb begin
        ext = rdata;
        case (load_op)
            LOAD_LB:  ext = sext8(byte_s);
            LOAD_LBU: ext = zext8(byte_s);
            LOAD_LH:  ext = sext16(half_s);
            LOAD_LHU: ext = zext16(half_s);
            LOAD_LW:  ext = rdata;
            default:  ext = rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM->WB pipeline register, load extension, result select,
// register-file write port, ID hazard destination and commit-trace port.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'hbfc0_0000
) (
    input  logic              clk,
    input  logic              resetn,
    wb_stage_if.slave         ms_bus,
    input  logic              ws_flush,
    input  logic              ws_hold,
    output logic              rf_we,
    output logic [GPR_W-1:0]  rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [GPR_W-1:0]  ws_fwd_dest,
    output logic [DATA_W-1:0] debug_wb_pc,
    output logic [3:0]        debug_wb_rf_wen,
    output logic [GPR_W-1:0]  debug_wb_rf_wnum,
    output logic [DATA_W-1:0] debug_wb_rf_wdata
);

    logic              ws_valid_r;
    ws_payload_t       payload_r;
    ws_payload_t       payload_in_s;

    logic              ws_ready_go_s;
    logic              ws_allowin_s;
    logic              load_en_s;
    logic              retire_s;
    logic              rf_we_s;
    logic [GPR_W-1:0]  rf_waddr_s;
    logic [DATA_W-1:0] rf_wdata_s;
    logic [GPR_W-1:0]  fwd_dest_s;
    logic [DATA_W-1:0] load_ext_s;

    // Handshake and retire qualification.
    always_comb begin
        ws_ready_go_s = !ws_hold;
        ws_allowin_s  = !ws_valid_r || ws_ready_go_s;
        load_en_s     = ms_bus.ms_to_ws_valid && ws_allowin_s && !ws_flush;
        retire_s      = ws_valid_r && ws_ready_go_s && !ws_flush;
    end

    // Gather the incoming payload from the MEM bus.
    always_comb begin
        payload_in_s              = '0;
        payload_in_s.pc           = ms_bus.ms_pc;
        payload_in_s.gr_we        = ms_bus.ms_gr_we;
        payload_in_s.dest         = ms_bus.ms_dest;
        payload_in_s.res_from_mem = ms_bus.ms_res_from_mem;
        payload_in_s.load_op      = ms_bus.ms_load_op;
        payload_in_s.addr_low     = ms_bus.ms_addr_low;
        payload_in_s.alu_result   = ms_bus.ms_alu_result;
        payload_in_s.mem_rdata    = ms_bus.ms_mem_rdata;
    end

    // Stage occupancy: flush kills, otherwise refill whenever the stage can accept.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ws_valid_r <= 1'b0;
        end else if (ws_flush) begin
            ws_valid_r <= 1'b0;
        end else if (ws_allowin_s) begin
            ws_valid_r <= ms_bus.ms_to_ws_valid;
        end else begin
            ws_valid_r <= ws_valid_r;
        end
    end

    // Payload register; a held instruction stays frozen until it retires.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            payload_r <= payload_reset(PC_RESET);
        end else if (load_en_s) begin
            payload_r <= payload_in_s;
        end else begin
            payload_r <= payload_r;
        end
    end

    wb_stage_load_ext u_load_ext (
        .rdata    (payload_r.mem_rdata),
        .load_op  (payload_r.load_op),
        .addr_low (payload_r.addr_low),
        .ext      (load_ext_s)
    );

    // Write port: address and data are zeroed when idle because the register
    // file bypasses on address match even without a write enable.
    always_comb begin
        rf_we_s = retire_s && payload_r.gr_we && (payload_r.dest != 5'd0);
        if (rf_we_s) begin
            rf_waddr_s = payload_r.dest;
            rf_wdata_s = payload_r.res_from_mem ? load_ext_s : payload_r.alu_result;
        end else begin
            rf_waddr_s = 5'd0;
            rf_wdata_s = 32'd0;
        end
    end

    // Hazard destination is reported while held so ID keeps stalling.
    always_comb begin
        if (ws_valid_r && payload_r.gr_we) begin
            fwd_dest_s = payload_r.dest;
        end else begin
            fwd_dest_s = 5'd0;
        end
    end

    assign ms_bus.ws_allowin = ws_allowin_s;
    assign rf_we             = rf_we_s;
    assign rf_waddr          = rf_waddr_s;
    assign rf_wdata          = rf_wdata_s;
    assign ws_fwd_dest       = fwd_dest_s;
    assign debug_wb_pc       = payload_r.pc;
    assign debug_wb_rf_wen   = {4{rf_we_s}};
    assign debug_wb_rf_wnum  = rf_waddr_s;
    assign debug_wb_rf_wdata = rf_wdata_s;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_wb_stage;
    import wb_stage_pkg::*;

    localparam logic [31:0] PC_RST = 32'hbfc0_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ws_flush;
    logic        ws_hold;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  ws_fwd_dest;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    int total = 0;
    int bad   = 0;

    wb_stage_if bus ();

    wb_stage #(.PC_RESET(PC_RST)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .ms_bus            (bus),
        .ws_flush          (ws_flush),
        .ws_hold           (ws_hold),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .ws_fwd_dest       (ws_fwd_dest),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ms_to_ws_valid  = 1'b0;
        bus.ms_pc           = 32'd0;
        bus.ms_gr_we        = 1'b0;
        bus.ms_dest         = 5'd0;
        bus.ms_res_from_mem = 1'b0;
        bus.ms_load_op      = 3'd0;
        bus.ms_addr_low     = 2'd0;
        bus.ms_alu_result   = 32'd0;
        bus.ms_mem_rdata    = 32'd0;
        ws_flush            = 1'b0;
        ws_hold             = 1'b0;
    endtask

    task automatic send(input logic [31:0] pc, input logic gr_we, input logic [4:0] dest,
                        input logic rfm, input logic [2:0] op, input logic [1:0] al,
                        input logic [31:0] alu, input logic [31:0] rdata);
        bus.ms_to_ws_valid  = 1'b1;
        bus.ms_pc           = pc;
        bus.ms_gr_we        = gr_we;
        bus.ms_dest         = dest;
        bus.ms_res_from_mem = rfm;
        bus.ms_load_op      = op;
        bus.ms_addr_low     = al;
        bus.ms_alu_result   = alu;
        bus.ms_mem_rdata    = rdata;
    endtask

    // Reference load extension computed with plain shifts and magnitude tests.
    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] op,
                                             input logic [1:0] al);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * al)) & 32'h0000_00ff;
        h = (w >> (16 * al[1])) & 32'h0000_ffff;
        if (op == LOAD_LB)  return (b > 32'd127)   ? (b | 32'hffff_ff00) : b;
        if (op == LOAD_LBU) return b;
        if (op == LOAD_LH)  return (h > 32'd32767) ? (h | 32'hffff_0000) : h;
        if (op == LOAD_LHU) return h;
        return w;
    endfunction

    task automatic test_reset();
        resetn = 1'b0;
        idle_inputs();
        tick();
        tick();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we got=%0h exp=0", rf_we); end
        total++; if (rf_waddr !== 5'd0) begin bad++; $display("FAIL reset_rf_waddr got=%0h exp=0", rf_waddr); end
        total++; if (rf_wdata !== 32'd0) begin bad++; $display("FAIL reset_rf_wdata got=%0h exp=0", rf_wdata); end
        total++; if (ws_fwd_dest !== 5'd0) begin bad++; $display("FAIL reset_fwd got=%0h exp=0", ws_fwd_dest); end
        total++; if (bus.ws_allowin !== 1'b1) begin bad++; $display("FAIL reset_allowin got=%0h exp=1", bus.ws_allowin); end
        total++; if (debug_wb_pc !== PC_RST) begin bad++; $display("FAIL reset_pc got=%0h exp=%0h", debug_wb_pc, PC_RST); end
        total++; if (debug_wb_rf_wen !== 4'h0) begin bad++; $display("FAIL reset_wen got=%0h exp=0", debug_wb_rf_wen); end
        resetn = 1'b1;
        tick();
        total++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0) begin bad++; $display("FAIL idle_we got=%0h/%0h exp=0/0", rf_we, rf_waddr); end
    endtask

    task automatic test_alu_write();
        send(32'h0000_1000, 1'b1, 5'd5, 1'b0, LOAD_LW, 2'd0, 32'h1234_5678, 32'hdead_beef);
        tick();
        idle_inputs();
        #1;
        total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL alu_we got=%0h exp=1", rf_we); end
        total++; if (rf_waddr !== 5'd5) begin bad++; $display("FAIL alu_waddr got=%0h exp=5", rf_waddr); end
        total++; if (rf_wdata !== 32'h1234_5678) begin bad++; $display("FAIL alu_wdata got=%0h exp=12345678", rf_wdata); end
        total++; if (debug_wb_rf_wen !== 4'hf) begin bad++; $display("FAIL alu_wen got=%0h exp=f", debug_wb_rf_wen); end
        total++; if (debug_wb_pc !== 32'h0000_1000) begin bad++; $display("FAIL alu_pc got=%0h exp=1000", debug_wb_pc); end
        total++; if (debug_wb_rf_wnum !== 5'd5 || debug_wb_rf_wdata !== 32'h1234_5678) begin
            bad++; $display("FAIL alu_trace got=%0h/%0h exp=5/12345678", debug_wb_rf_wnum, debug_wb_rf_wdata); end
        tick();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL alu_after got=%0h exp=0", rf_we); end
    endtask

    task automatic test_loads();
        logic [2:0]  ops  [5] = '{LOAD_LB, LOAD_LBU, LOAD_LH, LOAD_LHU, LOAD_LW};
        logic [1:0]  als  [5] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd1};
        logic [31:0] exps [5] = '{32'hffff_ff80, 32'h0000_007f, 32'hffff_80ff, 32'h0000_7f01, 32'h80ff_7f01};
        for (int i = 0; i < 5; i++) begin
            send(32'h0000_2000 + 32'(i * 4), 1'b1, 5'(10 + i), 1'b1, ops[i], als[i],
                 32'hdead_beef, 32'h80ff_7f01);
            tick();
            idle_inputs();
            #1;
            total++; if (rf_we !== 1'b1 || rf_wdata !== exps[i]) begin
                bad++; $display("FAIL load_%0d got=%0h/%0h exp=1/%0h", i, rf_we, rf_wdata, exps[i]); end
            tick();
        end
    endtask

    task automatic test_hold();
        int writes;
        send(32'h0000_3000, 1'b1, 5'd7, 1'b0, LOAD_LW, 2'd0, 32'h0000_0777, 32'd0);
        tick();
        ws_hold = 1'b1;
        send(32'h0000_3004, 1'b1, 5'd9, 1'b0, LOAD_LW, 2'd0, 32'h0000_0999, 32'd0);
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL hold_we c=%0d got=%0h exp=0", c, rf_we); end
            total++; if (bus.ws_allowin !== 1'b0) begin bad++; $display("FAIL hold_allowin c=%0d got=%0h exp=0", c, bus.ws_allowin); end
            total++; if (ws_fwd_dest !== 5'd7) begin bad++; $display("FAIL hold_fwd c=%0d got=%0h exp=7", c, ws_fwd_dest); end
            tick();
        end
        ws_hold = 1'b0;
        #1;
        writes = 0;
        if (rf_we === 1'b1) writes++;
        total++; if (rf_waddr !== 5'd7 || rf_wdata !== 32'h0000_0777 || bus.ws_allowin !== 1'b1) begin
            bad++; $display("FAIL release got=%0h/%0h/%0h exp=7/777/1", rf_waddr, rf_wdata, bus.ws_allowin); end
        tick();
        idle_inputs();
        #1;
        total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h0000_0999) begin
            bad++; $display("FAIL b2b got=%0h/%0h/%0h exp=1/9/999", rf_we, rf_waddr, rf_wdata); end
        tick();
        if (rf_we === 1'b1) writes++;
        total++; if (writes !== 1) begin bad++; $display("FAIL hold_writes got=%0d exp=1", writes); end
    endtask

    task automatic test_flush();
        send(32'h0000_4000, 1'b1, 5'd3, 1'b0, LOAD_LW, 2'd0, 32'h0000_0333, 32'd0);
        tick();
        ws_flush = 1'b1;
        send(32'h0000_4004, 1'b1, 5'd4, 1'b0, LOAD_LW, 2'd0, 32'h0000_0444, 32'd0);
        #1;
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL flush_kill got=%0h exp=0", rf_we); end
        tick();
        idle_inputs();
        #1;
        total++; if (rf_we !== 1'b0 || ws_fwd_dest !== 5'd0) begin
            bad++; $display("FAIL flush_after got=%0h/%0h exp=0/0", rf_we, ws_fwd_dest); end
        total++; if (debug_wb_pc !== 32'h0000_4000) begin bad++; $display("FAIL flush_pc got=%0h exp=4000", debug_wb_pc); end
    endtask

    task automatic test_zero_dest();
        send(32'h0000_5000, 1'b1, 5'd0, 1'b0, LOAD_LW, 2'd0, 32'hffff_ffff, 32'd0);
        tick();
        idle_inputs();
        #1;
        total++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || debug_wb_rf_wen !== 4'h0) begin
            bad++; $display("FAIL zero_dest got=%0h/%0h/%0h exp=0/0/0", rf_we, rf_waddr, rf_wdata); end
        tick();
    endtask

    task automatic test_reset_mid_hold();
        send(32'h0000_6000, 1'b1, 5'd12, 1'b0, LOAD_LW, 2'd0, 32'h0000_0cc0, 32'd0);
        tick();
        idle_inputs();
        ws_hold = 1'b1;
        #1;
        total++; if (ws_fwd_dest !== 5'd12) begin bad++; $display("FAIL rsthold_fwd got=%0h exp=c", ws_fwd_dest); end
        resetn = 1'b0;
        tick();
        resetn  = 1'b1;
        ws_hold = 1'b0;
        #1;
        total++; if (rf_we !== 1'b0 || ws_fwd_dest !== 5'd0 || debug_wb_pc !== PC_RST) begin
            bad++; $display("FAIL rsthold got=%0h/%0h/%0h exp=0/0/%0h", rf_we, ws_fwd_dest, debug_wb_pc, PC_RST); end
        tick();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rsthold_later got=%0h exp=0", rf_we); end
    endtask

    task automatic test_random();
        logic        m_valid, m_gr_we, m_rfm;
        logic [31:0] m_pc, m_alu, m_rdata;
        logic [4:0]  m_dest;
        logic [2:0]  m_op;
        logic [1:0]  m_al;
        logic        e_allow, e_retire, e_we;
        logic [31:0] e_wdata;
        logic [4:0]  e_waddr, e_fwd;
        resetn = 1'b0;
        idle_inputs();
        tick();
        resetn = 1'b1;
        m_valid = 1'b0; m_gr_we = 1'b0; m_rfm = 1'b0; m_pc = PC_RST; m_alu = 32'd0;
        m_rdata = 32'd0; m_dest = 5'd0; m_op = 3'd0; m_al = 2'd0;
        for (int n = 0; n < 400; n++) begin
            send($urandom, ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                 $urandom, $urandom);
            bus.ms_to_ws_valid = ($urandom_range(0, 3) != 0);
            ws_flush           = ($urandom_range(0, 7) == 0);
            ws_hold            = ($urandom_range(0, 3) == 0);
            #1;
            e_allow  = !m_valid || !ws_hold;
            e_retire = m_valid && !ws_hold && !ws_flush;
            e_we     = e_retire && m_gr_we && (m_dest != 5'd0);
            e_waddr  = e_we ? m_dest : 5'd0;
            e_wdata  = !e_we ? 32'd0 : (m_rfm ? ref_load(m_rdata, m_op, m_al) : m_alu);
            e_fwd    = (m_valid && m_gr_we) ? m_dest : 5'd0;
            total++; if (rf_we !== e_we || debug_wb_rf_wen !== {4{e_we}}) begin
                bad++; $display("FAIL rnd_we n=%0d got=%0h exp=%0h", n, rf_we, e_we); end
            total++; if (rf_waddr !== e_waddr || debug_wb_rf_wnum !== e_waddr) begin
                bad++; $display("FAIL rnd_waddr n=%0d got=%0h exp=%0h", n, rf_waddr, e_waddr); end
            total++; if (rf_wdata !== e_wdata || debug_wb_rf_wdata !== e_wdata) begin
                bad++; $display("FAIL rnd_wdata n=%0d got=%0h exp=%0h", n, rf_wdata, e_wdata); end
            total++; if (ws_fwd_dest !== e_fwd) begin bad++; $display("FAIL rnd_fwd n=%0d got=%0h exp=%0h", n, ws_fwd_dest, e_fwd); end
            total++; if (bus.ws_allowin !== e_allow) begin bad++; $display("FAIL rnd_allowin n=%0d got=%0h exp=%0h", n, bus.ws_allowin, e_allow); end
            total++; if (debug_wb_pc !== m_pc) begin bad++; $display("FAIL rnd_pc n=%0d got=%0h exp=%0h", n, debug_wb_pc, m_pc); end
            if (bus.ms_to_ws_valid && e_allow && !ws_flush) begin
                m_pc = bus.ms_pc; m_gr_we = bus.ms_gr_we; m_dest = bus.ms_dest; m_rfm = bus.ms_res_from_mem;
                m_op = bus.ms_load_op; m_al = bus.ms_addr_low; m_alu = bus.ms_alu_result; m_rdata = bus.ms_mem_rdata;
            end
            if (ws_flush) m_valid = 1'b0;
            else if (e_allow) m_valid = bus.ms_to_ws_valid;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_loads();
        test_hold();
        test_flush();
        test_zero_dest();
        test_reset_mid_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back pipeline stage of the 5-stage CPU; sits directly upstream of the register file and drives its write port (we/waddr/wdata).
- Holds the MEM→WB pipeline register, performs load-data byte/halfword selection and extension, and picks the ALU or memory result.
- Also supplies the WB destination to ID-stage hazard logic and the commit-trace debug port.

Parameters:
- PC_RESET, 32'hbfc0_0000, value of the latched PC and debug_wb_pc after reset.

Ports:
- clk  in  1  core clock
- resetn  in  1  synchronous, active-low reset
- ms_to_ws_valid  in  1  MEM stage presents a valid instruction
- ms_pc  in  32  instruction PC
- ms_gr_we  in  1  instruction writes a GPR
- ms_dest  in  5  destination GPR number
- ms_res_from_mem  in  1  result comes from load data, not the ALU
- ms_load_op  in  3  load type (see package codes)
- ms_addr_low  in  2  data address bits [1:0]
- ms_alu_result  in  32  ALU / address result
- ms_mem_rdata  in  32  raw word read from data SRAM
- ws_flush  in  1  exception flush: kill the WB instruction
- ws_hold  in  1  external stall: WB may not retire this cycle
- ws_allowin  out  1  WB can accept a new instruction
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- ws_fwd_dest  out  5  WB destination for ID hazard check (0 = none)
- debug_wb_pc  out  32  retiring PC
- debug_wb_rf_wen  out  4  byte write enables for trace ({4{rf_we}})
- debug_wb_rf_wnum  out  5  equals rf_waddr
- debug_wb_rf_wdata  out  32  equals rf_wdata

Behaviour:
- Clock is `clk`. Reset `resetn` is synchronous and active-low.
- State: ws_valid plus a payload register holding pc, gr_we, dest, res_from_mem, load_op, addr_low, alu_result and mem_rdata.
- Reset: ws_valid=0; payload cleared and pc=PC_RESET.
  - All outputs are therefore 0 after reset, except ws_allowin=1 and debug_wb_pc=PC_RESET.
- Control:
  - ws_ready_go = !ws_hold.
  - ws_allowin = !ws_valid | ws_ready_go.
- Priority of the ws_valid update, evaluated each posedge:
  1. reset
  2. ws_flush → ws_valid=0
  3. ws_allowin → ws_valid = ms_to_ws_valid
  4. otherwise hold
- Payload update:
  - Loads only when ms_to_ws_valid & ws_allowin & !ws_flush.
  - Otherwise retains its value; a held instruction stays stable indefinitely.
- Retire: retire = ws_valid & ws_ready_go & !ws_flush. The register is written in the same cycle as retire; zero extra latency.
- rf_we = retire & gr_we & (dest != 0).
- rf_waddr = rf_we ? dest : 5'd0.
  - Mandatory: the register file bypasses on address match regardless of we, so a nonzero idle waddr would corrupt reads.
- rf_wdata = res_from_mem ? load_ext(mem_rdata, load_op, addr_low) : alu_result. It is forced to 0 when !rf_we.
- ws_fwd_dest = (ws_valid & gr_we) ? dest : 0. It is reported even while held, so ID stalls correctly.
- Load extension:
  - LB/LBU select byte addr_low, then sign- or zero-extend.
  - LH/LHU select halfword addr_low[1], then sign- or zero-extend.
  - LW passes the word through; addr_low is ignored.
  - Reserved codes 5..7 behave as LW.
- Debug port mirrors rf_* combinationally. debug_wb_pc = payload pc.
- Boundary conditions:
  - Back-to-back instructions: a new payload is accepted in the same edge the previous one retires.
  - Hold: ws_allowin=0 only if ws_valid; an empty stage accepts even during hold, and retirement waits.
  - Flush together with a new arrival: the flush wins, ws_valid=0 and the payload is not loaded.
  - Reset mid-hold: the instruction is discarded and no write occurs.
  - A write to $0 never asserts rf_we.

Decomposition:
- defines.vh: LOAD_LW=3'd0, LOAD_LB=3'd1, LOAD_LBU=3'd2, LOAD_LH=3'd3, LOAD_LHU=3'd4; GPR number width 5; data width 32.
- Sub-module load_ext: combinational; inputs rdata[31:0], load_op[2:0], addr_low[1:0]; output ext[31:0]. Shared later with any LWL/LWR work.

Test Plan:
- Reset, then idle: all outputs 0, ws_allowin=1, rf_waddr=0, debug_wb_pc=PC_RESET.
- ALU write, dest=5, alu=32'h1234_5678 → next cycle rf_we=1, rf_waddr=5, rf_wdata=32'h1234_5678, debug_wb_rf_wen=4'hf.
- Loads with mem_rdata=32'h80FF_7F01:
  - LB, addr_low=3 → 32'hFFFF_FF80.
  - LBU, addr_low=1 → 32'h0000_007F.
  - LH, addr_low=2 → 32'hFFFF_80FF.
  - LHU, addr_low=0 → 32'h0000_7F01.
  - LW → 32'h80FF_7F01.
- Hold 3 cycles with valid write dest=7:
  - rf_we=0 and ws_allowin=0 throughout; ws_fwd_dest=7.
  - Release → exactly one write in that cycle; a new instruction is accepted on the same edge.
- Flush with ms_to_ws_valid=1 in the same cycle → ws_valid=0 next cycle, rf_we=0, ws_fwd_dest=0.
- Write to dest=0 with gr_we=1 → rf_we=0, rf_waddr=0, rf_wdata=0; also apply resetn=0 during a hold → no write afterwards.
